hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter LU_STALL_CYCLES, default 1, range 1..3: bubble cycles inserted per load-use hazard.
REQ-002 SHALL use register-address width MSB_REG_FILE (5) from instructions_pkg.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 rs1_addr_ps2, rs2_addr_ps2  input  MSB_REG_FILE  decode-stage source addresses.
REQ-006 rs1_used_ps2, rs2_used_ps2  input  1  decoded instruction actually reads rs1/rs2.
REQ-007 rd_Ps3  input  MSB_REG_FILE  execute-stage destination.
REQ-008 rd_wr_en_ps3, is_load_ps3  input  1  execute-stage instruction writes rd / is a load.
REQ-009 branch_taken_ps3  input  1  execute-stage redirect (branch or jump taken).
REQ-010 mem_req_ps4, dmem_ready  input  1  memory-stage access pending / data memory done.
REQ-011 stall_pc, stall_ps2, stall_ps3, stall_ps4  output  1  hold PC / IF-ID / ID-EX / EX-MEM registers.
REQ-012 bubble_ps3  output  1  load NOP into ID-EX.
REQ-013 flush_ps2  output  1  invalidate IF-ID.
REQ-014 hz_state  output  2  current FSM state (RUN=0, LU_STALL=1, MEM_WAIT=2).

Function
REQ-015 lu_hit SHALL be is_load_ps3 & rd_wr_en_ps3 & (rd_Ps3 != 0) & ((rs1_used_ps2 & rs1_addr_ps2 == rd_Ps3) | (rs2_used_ps2 & rs2_addr_ps2 == rd_Ps3)).
REQ-016 mem_hold SHALL be mem_req_ps4 & ~dmem_ready.
REQ-017 Priority, evaluated combinationally each cycle: mem_hold > branch_taken_ps3 > lu_hit / LU_STALL.
REQ-018 Freeze (mem_hold, any state): stall_pc, stall_ps2, stall_ps3, stall_ps4 = 1; bubble_ps3 = flush_ps2 = 0; next state MEM_WAIT; remaining-bubble counter held.
REQ-019 Flush (branch_taken_ps3, no mem_hold): flush_ps2 = bubble_ps3 = 1; all stalls 0; next state RUN; counter cleared to 0.
REQ-020 RUN with lu_hit: stall_pc = stall_ps2 = bubble_ps3 = 1, same cycle; if LU_STALL_CYCLES > 1, counter <= LU_STALL_CYCLES-1, next LU_STALL; otherwise stay RUN.
REQ-021 LU_STALL: stall_pc = stall_ps2 = bubble_ps3 = 1; counter decrements; at counter == 1, next RUN.
REQ-022 MEM_WAIT with dmem_ready (mem_hold = 0): if counter != 0 return to LU_STALL, else RUN; outputs that cycle follow the target-state rules of REQ-019..021 combinationally.
REQ-023 No hazard, no hold, no branch: all outputs 0; state RUN.
REQ-024 Latency: every output SHALL be asserted in the cycle its cause is present; no registered-output delay.
REQ-025 Writes to x0 SHALL never cause a stall.
REQ-026 hz_state value 3 unreachable; if entered, SHALL return to RUN next cycle with all outputs 0.

Reset
REQ-027 While rst = 1: state RUN, counter 0, all control outputs 0, hz_state 0, regardless of other inputs.
REQ-028 Reset asserted mid-LU_STALL or mid-MEM_WAIT SHALL abandon the pending stall; first cycle after release behaves as RUN.

Configuration
REQ-029 Macro HAZARD_PERF_CNT_EN: when defined, outputs lu_stall_cnt[31:0] and mem_stall_cnt[31:0] SHALL exist, incrementing once per cycle with bubble_ps3 & ~flush_ps2 and with mem_hold respectively, saturating at 0xFFFF_FFFF, cleared by rst.
REQ-030 Without HAZARD_PERF_CNT_EN: those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-031 lw x5 in ps3, add reads x5 in ps2, LU_STALL_CYCLES=1 -> one cycle stall_pc=stall_ps2=bubble_ps3=1, then all 0.
REQ-032 Same with rd_Ps3=0 or rs2_used_ps2=0 on matching addr -> no stall.
REQ-033 LU_STALL_CYCLES=3, load-use hit -> bubble_ps3 high exactly 3 cycles, hz_state 0,1,1,0.
REQ-034 LU_STALL counter 2, mem_hold for 4 cycles -> all four stalls high 4 cycles, hz_state 2, then 2 more bubble cycles.
REQ-035 branch_taken_ps3 and lu_hit same cycle -> flush_ps2=bubble_ps3=1, stall_pc=0, next state RUN; with mem_hold also high -> freeze only, no flush.
REQ-036 rst pulsed during MEM_WAIT -> outputs 0 next cycle; with HAZARD_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Register-file width package and the hazard-control signal bundle.
// The master side is the pipeline datapath; the slave side is the hazard controller.
package instructions_pkg;
  localparam int MSB_REG_FILE = 5;
endpackage

interface hazard_ctrl_if;
  import instructions_pkg::*;

  logic [MSB_REG_FILE-1:0] rs1_addr_ps2;
  logic [MSB_REG_FILE-1:0] rs2_addr_ps2;
  logic                    rs1_used_ps2;
  logic                    rs2_used_ps2;
  logic [MSB_REG_FILE-1:0] rd_Ps3;
  logic                    rd_wr_en_ps3;
  logic                    is_load_ps3;
  logic                    branch_taken_ps3;
  logic                    mem_req_ps4;
  logic                    dmem_ready;

  logic                    stall_pc;
  logic                    stall_ps2;
  logic                    stall_ps3;
  logic                    stall_ps4;
  logic                    bubble_ps3;
  logic                    flush_ps2;
  logic [1:0]              hz_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]             lu_stall_cnt;
  logic [31:0]             mem_stall_cnt;
`endif

  modport master (
    output rs1_addr_ps2, rs2_addr_ps2, rs1_used_ps2, rs2_used_ps2,
    output rd_Ps3, rd_wr_en_ps3, is_load_ps3, branch_taken_ps3,
    output mem_req_ps4, dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
    input  lu_stall_cnt, mem_stall_cnt,
`endif
    input  stall_pc, stall_ps2, stall_ps3, stall_ps4, bubble_ps3, flush_ps2, hz_state
  );

  modport slave (
    input  rs1_addr_ps2, rs2_addr_ps2, rs1_used_ps2, rs2_used_ps2,
    input  rd_Ps3, rd_wr_en_ps3, is_load_ps3, branch_taken_ps3,
    input  mem_req_ps4, dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
    output lu_stall_cnt, mem_stall_cnt,
`endif
    output stall_pc, stall_ps2, stall_ps3, stall_ps4, bubble_ps3, flush_ps2, hz_state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, memory-wait freeze and branch flush.
// Optional stall performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
  import instructions_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ILLEGAL  = 2'd3
  } state_e;

  localparam logic [1:0] LU_REMAIN = 2'(LU_STALL_CYCLES - 1);

  state_e     state_q, state_d, eff_state;
  logic [1:0] cnt_q, cnt_d;

  logic lu_hit, mem_hold;
  logic stall_pc_w, stall_ps2_w, stall_ps3_w, stall_ps4_w, bubble_w, flush_w;

  assign lu_hit = hz.is_load_ps3 & hz.rd_wr_en_ps3 & (hz.rd_Ps3 != '0) &
                  ((hz.rs1_used_ps2 & (hz.rs1_addr_ps2 == hz.rd_Ps3)) |
                   (hz.rs2_used_ps2 & (hz.rs2_addr_ps2 == hz.rd_Ps3)));
  assign mem_hold = hz.mem_req_ps4 & ~hz.dmem_ready;

  always_comb begin
    stall_pc_w  = 1'b0;
    stall_ps2_w = 1'b0;
    stall_ps3_w = 1'b0;
    stall_ps4_w = 1'b0;
    bubble_w    = 1'b0;
    flush_w     = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    eff_state   = state_q;

    if (state_q == ILLEGAL) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (mem_hold) begin
      stall_pc_w  = 1'b1;
      stall_ps2_w = 1'b1;
      stall_ps3_w = 1'b1;
      stall_ps4_w = 1'b1;
      state_d     = MEM_WAIT;
    end else if (hz.branch_taken_ps3) begin
      flush_w  = 1'b1;
      bubble_w = 1'b1;
      state_d  = RUN;
      cnt_d    = '0;
    end else begin
      // Leaving MEM_WAIT resumes whatever bubble sequence the freeze interrupted.
      if (state_q == MEM_WAIT) eff_state = (cnt_q != '0) ? LU_STALL : RUN;
      state_d = RUN;
      case (eff_state)
        LU_STALL: begin
          stall_pc_w  = 1'b1;
          stall_ps2_w = 1'b1;
          bubble_w    = 1'b1;
          if (cnt_q <= 2'd1) begin
            cnt_d = '0;
          end else begin
            cnt_d   = cnt_q - 2'd1;
            state_d = LU_STALL;
          end
        end
        default: begin
          if (lu_hit) begin
            stall_pc_w  = 1'b1;
            stall_ps2_w = 1'b1;
            bubble_w    = 1'b1;
            if (LU_STALL_CYCLES > 1) begin
              cnt_d   = LU_REMAIN;
              state_d = LU_STALL;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are combinational so each one appears in the same cycle as its cause.
  assign hz.stall_pc   = ~rst & stall_pc_w;
  assign hz.stall_ps2  = ~rst & stall_ps2_w;
  assign hz.stall_ps3  = ~rst & stall_ps3_w;
  assign hz.stall_ps4  = ~rst & stall_ps4_w;
  assign hz.bubble_ps3 = ~rst & bubble_w;
  assign hz.flush_ps2  = ~rst & flush_w;
  assign hz.hz_state   = rst ? 2'd0 : state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt_q, mem_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      if (bubble_w && !flush_w && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + 32'd1;
      if (mem_hold && (mem_cnt_q != '1)) mem_cnt_q <= mem_cnt_q + 32'd1;
    end
  end

  assign hz.lu_stall_cnt  = lu_cnt_q;
  assign hz.mem_stall_cnt = mem_cnt_q;
`endif

endmodule
